// File: rtl/store_buffer_fwd_pkg.sv
`default_nettype none
// ============================================================================
// store_buffer_fwd_pkg : shared types and helpers for the store queue
// Revision: 1.0
// ============================================================================
package store_buffer_fwd_pkg;

  localparam int C_DEPTH   = 16;
  localparam int C_N_DISP  = 2;
  localparam int C_N_EXEC  = 2;
  localparam int C_N_DRAIN = 2;
  localparam int C_N_LOAD  = 2;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  // Data is held already shifted into its word lanes; bmask marks those lanes.
  typedef struct packed {
    logic        valid;
    logic        ready;
    logic        committed;
    mem_size_e   size;
    logic [3:0]  bmask;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  function automatic logic [3:0] size_to_bmask(input mem_size_e size);
    case (size)
      MEM_BYTE: return 4'b0001;
      MEM_HALF: return 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_align(input logic [31:0] data, input logic [1:0] offset);
    return data << {offset, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_fwd_fwd_lane.sv
`default_nettype none
// ============================================================================
// sb_fwd_lane : one load port's youngest-first scan/merge over the store queue
// Revision: 1.0
// ============================================================================
module sb_fwd_lane
  import store_buffer_fwd_pkg::*;
#(
  parameter  int DEPTH = C_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ent_valid,
  input  logic [DEPTH-1:0] ent_ready,
  input  logic [3:0]       ent_bmask [DEPTH],
  input  logic [29:0]      ent_word  [DEPTH],
  input  logic [31:0]      ent_data  [DEPTH],
  input  logic [IDX_W-1:0] head,
  input  logic [IDX_W-1:0] sq_tail,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [1:0]       ld_size,
  output logic [31:0]      ld_data,
  output logic [3:0]       ld_hit_mask,
  output logic             ld_fwd_full,
  output logic             ld_wait
);

  logic [3:0]       w_req;
  logic [3:0]       w_cov;
  logic [3:0]       w_new;
  logic [31:0]      w_data;
  logic             w_blocked;
  logic [IDX_W-1:0] w_n_older;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    w_req     = 4'(size_to_bmask(mem_size_e'(ld_size)) << ld_addr[1:0]);
    w_n_older = sq_tail - head;
    w_cov     = '0;
    w_new     = '0;
    w_data    = '0;
    w_blocked = 1'b0;
    w_idx     = '0;
    // Scanning stops once every requested lane is covered or an unready store is met.
    for (int j = 1; j <= DEPTH; j++) begin
      w_idx = sq_tail - IDX_W'(j);
      w_new = '0;
      if (ld_valid && !w_blocked && (w_cov != w_req) && (j <= int'(w_n_older)) && ent_valid[w_idx]) begin
        if (!ent_ready[w_idx])
          w_blocked = 1'b1;
        else if (ent_word[w_idx] == ld_addr[31:2])
          w_new = ent_bmask[w_idx] & w_req & ~w_cov;
      end
      for (int b = 0; b < 4; b++) begin
        if (w_new[b])
          w_data[8*b +: 8] = ent_data[w_idx][8*b +: 8];
      end
      w_cov = w_cov | w_new;
    end
  end

  assign ld_data     = w_data;
  assign ld_hit_mask = w_cov;
  assign ld_wait     = w_blocked;
  assign ld_fwd_full = ld_valid && !w_blocked && (w_cov == w_req);

endmodule
`default_nettype wire

// File: rtl/store_buffer_fwd.sv
`default_nettype none
// ============================================================================
// store_buffer_fwd : in-order store queue with byte-granular load forwarding
// Revision: 1.0
// ============================================================================
module store_buffer_fwd
  import store_buffer_fwd_pkg::*;
#(
  parameter  int DEPTH   = C_DEPTH,
  parameter  int N_DISP  = C_N_DISP,
  parameter  int N_EXEC  = C_N_EXEC,
  parameter  int N_DRAIN = C_N_DRAIN,
  parameter  int N_LOAD  = C_N_LOAD,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int CNT_W   = IDX_W + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_DISP-1:0]        disp_valid,
  input  logic [N_DISP*2-1:0]      disp_size,
  output logic                     disp_ready,
  output logic [N_DISP*IDX_W-1:0]  disp_idx,
  input  logic [N_EXEC-1:0]        exec_valid,
  input  logic [N_EXEC*IDX_W-1:0]  exec_idx,
  input  logic [N_EXEC*32-1:0]     exec_addr,
  input  logic [N_EXEC*32-1:0]     exec_data,
  input  logic [CNT_W-1:0]         commit_cnt,
  input  logic                     squash,
  output logic [N_DRAIN-1:0]       dc_req_valid,
  output logic [N_DRAIN*32-1:0]    dc_req_addr,
  output logic [N_DRAIN*32-1:0]    dc_req_data,
  output logic [N_DRAIN*2-1:0]     dc_req_size,
  input  logic [N_DRAIN-1:0]       dc_accept,
  output logic [CNT_W-1:0]         drained_cnt,
  output logic [IDX_W-1:0]         head,
  output logic [IDX_W-1:0]         tail,
  output logic [CNT_W-1:0]         count,
  input  logic [N_LOAD*IDX_W-1:0]  ld_sq_tail,
  input  logic [N_LOAD-1:0]        ld_valid,
  input  logic [N_LOAD*32-1:0]     ld_addr,
  input  logic [N_LOAD*2-1:0]      ld_size,
  output logic [N_LOAD*32-1:0]     ld_data,
  output logic [N_LOAD*4-1:0]      ld_hit_mask,
  output logic [N_LOAD-1:0]        ld_fwd_full,
  output logic [N_LOAD-1:0]        ld_wait
);

  sb_entry_t        r_entries [DEPTH];
  sb_entry_t        w_nxt     [DEPTH];
  logic [IDX_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count, r_committed;

  logic [CNT_W-1:0] w_alloc_n, w_drained, w_commit_tot, w_comm_nxt;
  logic [IDX_W-1:0] w_head_nxt;
  logic             w_do_disp;
  logic             w_run_v, w_run_a;

  logic [IDX_W-1:0] w_off       [DEPTH];
  logic [DEPTH-1:0] w_inuse;
  logic [DEPTH-1:0] w_ent_valid, w_ent_ready;
  logic [3:0]       w_ent_bmask [DEPTH];
  logic [29:0]      w_ent_word  [DEPTH];
  logic [31:0]      w_ent_data  [DEPTH];

  logic [IDX_W-1:0] w_dr_idx    [N_DRAIN];
  logic [N_DRAIN-1:0] w_dr_cand;

  assign head        = r_head;
  assign tail        = r_tail;
  assign count       = r_count;
  assign disp_ready  = (r_count <= CNT_W'(DEPTH - N_DISP));
  assign w_do_disp   = disp_ready && !squash;
  assign drained_cnt = w_drained;

  always_comb begin
    w_alloc_n = '0;
    for (int i = 0; i < N_DISP; i++)
      w_alloc_n = w_alloc_n + CNT_W'(disp_valid[i]);
  end

  for (genvar i = 0; i < N_DISP; i++) begin : g_disp_idx
    assign disp_idx[i*IDX_W +: IDX_W] = r_tail + IDX_W'(i);
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    assign w_off[e]       = IDX_W'(e) - r_head;
    assign w_inuse[e]     = ({1'b0, w_off[e]} < r_count);
    assign w_ent_valid[e] = r_entries[e].valid;
    assign w_ent_ready[e] = r_entries[e].ready;
    assign w_ent_bmask[e] = r_entries[e].bmask;
    assign w_ent_word[e]  = r_entries[e].addr[31:2];
    assign w_ent_data[e]  = r_entries[e].data;
  end

  for (genvar k = 0; k < N_DRAIN; k++) begin : g_drain
    assign w_dr_idx[k]  = r_head + IDX_W'(k);
    assign w_dr_cand[k] = r_entries[w_dr_idx[k]].valid && r_entries[w_dr_idx[k]].committed &&
                          r_entries[w_dr_idx[k]].ready;
    assign dc_req_addr[32*k +: 32] = dc_req_valid[k] ? r_entries[w_dr_idx[k]].addr : '0;
    assign dc_req_data[32*k +: 32] = dc_req_valid[k] ? r_entries[w_dr_idx[k]].data : '0;
    assign dc_req_size[2*k +: 2]   = dc_req_valid[k] ? r_entries[w_dr_idx[k]].size : MEM_BYTE;
  end

  // Only an unbroken run from head is presented, and only an unbroken accepted run frees.
  always_comb begin
    dc_req_valid = '0;
    w_drained    = '0;
    w_run_v      = 1'b1;
    w_run_a      = 1'b1;
    for (int k = 0; k < N_DRAIN; k++) begin
      w_run_v         = w_run_v & w_dr_cand[k];
      dc_req_valid[k] = w_run_v;
      w_run_a         = w_run_a & w_run_v & dc_accept[k];
      if (w_run_a)
        w_drained = w_drained + CNT_W'(1);
    end
  end

  assign w_commit_tot = r_committed + commit_cnt;
  assign w_comm_nxt   = w_commit_tot - w_drained;
  assign w_head_nxt   = r_head + w_drained[IDX_W-1:0];

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_nxt[e] = r_entries[e];
      if (w_inuse[e] && ({1'b0, w_off[e]} < w_commit_tot))
        w_nxt[e].committed = 1'b1;
      if (!squash) begin
        for (int p = 0; p < N_EXEC; p++) begin
          if (exec_valid[p] && (exec_idx[p*IDX_W +: IDX_W] == IDX_W'(e)) && r_entries[e].valid) begin
            w_nxt[e].addr  = exec_addr[32*p +: 32];
            w_nxt[e].data  = lane_align(exec_data[32*p +: 32], exec_addr[32*p +: 2]);
            w_nxt[e].bmask = 4'(size_to_bmask(r_entries[e].size) << exec_addr[32*p +: 2]);
            w_nxt[e].ready = 1'b1;
          end
        end
      end
      if (w_do_disp) begin
        for (int i = 0; i < N_DISP; i++) begin
          if (disp_valid[i] && ((r_tail + IDX_W'(i)) == IDX_W'(e))) begin
            w_nxt[e]       = '0;
            w_nxt[e].valid = 1'b1;
            w_nxt[e].size  = mem_size_e'(disp_size[2*i +: 2]);
          end
        end
      end
      if (w_inuse[e] && ({1'b0, w_off[e]} < w_drained))
        w_nxt[e] = '0;
      if (squash && w_inuse[e] && ({1'b0, w_off[e]} >= w_commit_tot))
        w_nxt[e] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++)
        r_entries[e] <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_committed <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++)
        r_entries[e] <= w_nxt[e];
      r_head      <= w_head_nxt;
      r_committed <= w_comm_nxt;
      if (squash) begin
        r_tail  <= w_head_nxt + w_comm_nxt[IDX_W-1:0];
        r_count <= w_comm_nxt;
      end else begin
        r_tail  <= r_tail + (w_do_disp ? w_alloc_n[IDX_W-1:0] : '0);
        r_count <= r_count - w_drained + (w_do_disp ? w_alloc_n : '0);
      end
    end
  end

  always @(posedge clock) begin
    if (!reset)
      assert (commit_cnt <= (r_count - r_committed));
  end

  for (genvar l = 0; l < N_LOAD; l++) begin : g_load
    sb_fwd_lane #(.DEPTH(DEPTH)) u_lane (
      .ent_valid   (w_ent_valid),
      .ent_ready   (w_ent_ready),
      .ent_bmask   (w_ent_bmask),
      .ent_word    (w_ent_word),
      .ent_data    (w_ent_data),
      .head        (r_head),
      .sq_tail     (ld_sq_tail[l*IDX_W +: IDX_W]),
      .ld_valid    (ld_valid[l]),
      .ld_addr     (ld_addr[32*l +: 32]),
      .ld_size     (ld_size[2*l +: 2]),
      .ld_data     (ld_data[32*l +: 32]),
      .ld_hit_mask (ld_hit_mask[4*l +: 4]),
      .ld_fwd_full (ld_fwd_full[l]),
      .ld_wait     (ld_wait[l])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer_fwd.sv
`default_nettype none
// ============================================================================
// tb_store_buffer_fwd : directed-vector bench for store_buffer_fwd
// Revision: 1.0
// ============================================================================
module tb_store_buffer_fwd;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  disp_valid;
  logic [3:0]  disp_size;
  logic        disp_ready;
  logic [7:0]  disp_idx;
  logic [1:0]  exec_valid;
  logic [7:0]  exec_idx;
  logic [63:0] exec_addr, exec_data;
  logic [4:0]  commit_cnt;
  logic        squash;
  logic [1:0]  dc_req_valid;
  logic [63:0] dc_req_addr, dc_req_data;
  logic [3:0]  dc_req_size;
  logic [1:0]  dc_accept;
  logic [4:0]  drained_cnt;
  logic [3:0]  head, tail;
  logic [4:0]  count;
  logic [7:0]  ld_sq_tail;
  logic [1:0]  ld_valid;
  logic [63:0] ld_addr;
  logic [3:0]  ld_size;
  logic [63:0] ld_data;
  logic [7:0]  ld_hit_mask;
  logic [1:0]  ld_fwd_full, ld_wait;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  store_buffer_fwd dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_size(disp_size), .disp_ready(disp_ready), .disp_idx(disp_idx),
    .exec_valid(exec_valid), .exec_idx(exec_idx), .exec_addr(exec_addr), .exec_data(exec_data),
    .commit_cnt(commit_cnt), .squash(squash),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
    .dc_req_size(dc_req_size), .dc_accept(dc_accept), .drained_cnt(drained_cnt),
    .head(head), .tail(tail), .count(count),
    .ld_sq_tail(ld_sq_tail), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_data(ld_data), .ld_hit_mask(ld_hit_mask), .ld_fwd_full(ld_fwd_full), .ld_wait(ld_wait)
  );

  task automatic clear_in();
    disp_valid = '0; disp_size = '0; exec_valid = '0; exec_idx = '0;
    exec_addr = '0; exec_data = '0; commit_cnt = '0; squash = 1'b0;
    dc_accept = '0; ld_sq_tail = '0; ld_valid = '0; ld_addr = '0; ld_size = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clear_in();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic disp(input logic [1:0] v, input logic [1:0] s0, input logic [1:0] s1);
    disp_valid = v;
    disp_size  = {s1, s0};
    tick();
  endtask

  task automatic set_exec(input int p, input logic [3:0] idx, input logic [31:0] a, input logic [31:0] d);
    exec_valid[p]          = 1'b1;
    exec_idx[4*p +: 4]     = idx;
    exec_addr[32*p +: 32]  = a;
    exec_data[32*p +: 32]  = d;
  endtask

  task automatic set_load(input int p, input logic [3:0] sqt, input logic [31:0] a, input logic [1:0] s);
    ld_valid[p]         = 1'b1;
    ld_sq_tail[4*p +: 4] = sqt;
    ld_addr[32*p +: 32] = a;
    ld_size[2*p +: 2]   = s;
  endtask

  task automatic test_reset();
    do_reset();
    set_load(0, 4'd0, 32'h100, SZ_W);
    #1;
    n_vec++; if (head !== 4'd0 || tail !== 4'd0 || count !== 5'd0) begin n_err++; $display("FAIL reset_ptrs: got head=%0d tail=%0d count=%0d expected 0/0/0", head, tail, count); end
    n_vec++; if (disp_ready !== 1'b1 || dc_req_valid !== 2'b00 || drained_cnt !== 5'd0) begin n_err++; $display("FAIL reset_ctl: got ready=%b dcv=%b drained=%0d expected 1/00/0", disp_ready, dc_req_valid, drained_cnt); end
    n_vec++; if (ld_data !== 64'h0 || ld_hit_mask !== 8'h0 || ld_fwd_full !== 2'b00 || ld_wait !== 2'b00) begin n_err++; $display("FAIL reset_ld: got data=%h mask=%h full=%b wait=%b expected all 0", ld_data, ld_hit_mask, ld_fwd_full, ld_wait); end
    tick();
  endtask

  task automatic test_basic_drain();
    do_reset();
    disp_valid = 2'b11; disp_size = {SZ_W, SZ_W};
    #1;
    n_vec++; if (disp_idx !== 8'h10) begin n_err++; $display("FAIL t1_disp_idx: got %h expected 10", disp_idx); end
    tick();
    n_vec++; if (tail !== 4'd2 || count !== 5'd2) begin n_err++; $display("FAIL t1_alloc: got tail=%0d count=%0d expected 2/2", tail, count); end
    set_exec(0, 4'd0, 32'h100, 32'hAABBCCDD);
    tick();
    commit_cnt = 5'd1;
    tick();
    n_vec++; if (dc_req_valid !== 2'b01 || dc_req_addr[31:0] !== 32'h100 || dc_req_data[31:0] !== 32'hAABBCCDD || dc_req_size[1:0] !== SZ_W) begin
      n_err++; $display("FAIL t1_req: got v=%b a=%h d=%h s=%0d expected 01/100/aabbccdd/2", dc_req_valid, dc_req_addr[31:0], dc_req_data[31:0], dc_req_size[1:0]); end
    dc_accept = 2'b01;
    #1;
    n_vec++; if (drained_cnt !== 5'd1) begin n_err++; $display("FAIL t1_drained: got %0d expected 1", drained_cnt); end
    tick();
    n_vec++; if (head !== 4'd1 || count !== 5'd1 || dc_req_valid !== 2'b00) begin n_err++; $display("FAIL t1_after: got head=%0d count=%0d dcv=%b expected 1/1/00", head, count, dc_req_valid); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 7; i++) disp(2'b11, SZ_W, SZ_W);
    n_vec++; if (count !== 5'd14 || disp_ready !== 1'b1) begin n_err++; $display("FAIL t2_c14: got count=%0d ready=%b expected 14/1", count, disp_ready); end
    disp(2'b01, SZ_W, SZ_W);
    n_vec++; if (count !== 5'd15 || disp_ready !== 1'b0) begin n_err++; $display("FAIL t2_c15: got count=%0d ready=%b expected 15/0", count, disp_ready); end
    disp(2'b11, SZ_W, SZ_W);
    n_vec++; if (count !== 5'd15 || tail !== 4'd15) begin n_err++; $display("FAIL t2_drop: got count=%0d tail=%0d expected 15/15", count, tail); end
    set_exec(0, 4'd0, 32'h200, 32'h11111111);
    set_exec(1, 4'd1, 32'h204, 32'h22222222);
    tick();
    commit_cnt = 5'd2;
    tick();
    dc_accept = 2'b11;
    #1;
    n_vec++; if (drained_cnt !== 5'd2 || dc_req_addr !== {32'h204, 32'h200}) begin n_err++; $display("FAIL t2_drain: got drained=%0d addr=%h expected 2/0000020400000200", drained_cnt, dc_req_addr); end
    tick();
    n_vec++; if (head !== 4'd2 || count !== 5'd13 || disp_ready !== 1'b1) begin n_err++; $display("FAIL t2_freed: got head=%0d count=%0d ready=%b expected 2/13/1", head, count, disp_ready); end
    disp_valid = 2'b11; disp_size = {SZ_W, SZ_W};
    #1;
    n_vec++; if (disp_idx !== 8'h0F) begin n_err++; $display("FAIL t2_wrap_idx: got %h expected 0f", disp_idx); end
    tick();
    n_vec++; if (tail !== 4'd1 || count !== 5'd15) begin n_err++; $display("FAIL t2_wrap_tail: got tail=%0d count=%0d expected 1/15", tail, count); end
  endtask

  task automatic test_partial_fwd();
    do_reset();
    disp(2'b11, SZ_B, SZ_H);
    set_exec(0, 4'd0, 32'h103, 32'h000000EE);
    set_exec(1, 4'd1, 32'h100, 32'h00001122);
    tick();
    set_load(0, 4'd2, 32'h100, SZ_W);
    set_load(1, 4'd2, 32'h100, SZ_H);
    #1;
    n_vec++; if (ld_data[31:0] !== 32'hEE001122 || ld_hit_mask[3:0] !== 4'b1011 || ld_fwd_full[0] !== 1'b0 || ld_wait[0] !== 1'b0) begin
      n_err++; $display("FAIL t3_word: got d=%h m=%b f=%b w=%b expected ee001122/1011/0/0", ld_data[31:0], ld_hit_mask[3:0], ld_fwd_full[0], ld_wait[0]); end
    n_vec++; if (ld_data[63:32] !== 32'h00001122 || ld_hit_mask[7:4] !== 4'b0011 || ld_fwd_full[1] !== 1'b1) begin
      n_err++; $display("FAIL t3_half: got d=%h m=%b f=%b expected 00001122/0011/1", ld_data[63:32], ld_hit_mask[7:4], ld_fwd_full[1]); end
    set_load(0, 4'd1, 32'h103, SZ_B);
    set_load(1, 4'd2, 32'h104, SZ_W);
    #1;
    n_vec++; if (ld_data[31:0] !== 32'hEE000000 || ld_hit_mask[3:0] !== 4'b1000 || ld_fwd_full[0] !== 1'b1) begin
      n_err++; $display("FAIL t3_byte_old: got d=%h m=%b f=%b expected ee000000/1000/1", ld_data[31:0], ld_hit_mask[3:0], ld_fwd_full[0]); end
    n_vec++; if (ld_data[63:32] !== 32'h0 || ld_hit_mask[7:4] !== 4'b0000 || ld_fwd_full[1] !== 1'b0) begin
      n_err++; $display("FAIL t3_miss: got d=%h m=%b f=%b expected 0/0000/0", ld_data[63:32], ld_hit_mask[7:4], ld_fwd_full[1]); end
    tick();
    commit_cnt = 5'd2;
    tick();
    set_load(0, 4'd2, 32'h100, SZ_W);
    #1;
    n_vec++; if (dc_req_valid !== 2'b11 || dc_req_data !== 64'h00001122_EE000000 || dc_req_size !== {SZ_H, SZ_B}) begin
      n_err++; $display("FAIL t3_lane_req: got v=%b d=%h s=%b expected 11/00001122ee000000/0100", dc_req_valid, dc_req_data, dc_req_size); end
    n_vec++; if (ld_data[31:0] !== 32'hEE001122) begin n_err++; $display("FAIL t3_committed_fwd: got %h expected ee001122", ld_data[31:0]); end
    tick();
  endtask

  task automatic test_wait();
    do_reset();
    disp(2'b01, SZ_W, SZ_W);
    set_load(0, 4'd1, 32'h300, SZ_W);
    #1;
    n_vec++; if (ld_wait[0] !== 1'b1 || ld_fwd_full[0] !== 1'b0) begin n_err++; $display("FAIL t4_wait: got w=%b f=%b expected 1/0", ld_wait[0], ld_fwd_full[0]); end
    set_exec(0, 4'd0, 32'h300, 32'h12345678);
    #1;
    n_vec++; if (ld_wait[0] !== 1'b1) begin n_err++; $display("FAIL t4_same_cycle: got w=%b expected 1", ld_wait[0]); end
    tick();
    set_load(0, 4'd1, 32'h300, SZ_W);
    #1;
    n_vec++; if (ld_wait[0] !== 1'b0 || ld_fwd_full[0] !== 1'b1 || ld_data[31:0] !== 32'h12345678 || ld_hit_mask[3:0] !== 4'b1111) begin
      n_err++; $display("FAIL t4_filled: got w=%b f=%b d=%h m=%b expected 0/1/12345678/1111", ld_wait[0], ld_fwd_full[0], ld_data[31:0], ld_hit_mask[3:0]); end
    tick();
  endtask

  task automatic test_squash();
    do_reset();
    for (int i = 0; i < 3; i++) disp(2'b11, SZ_W, SZ_W);
    set_exec(0, 4'd0, 32'h400, 32'hA0A0A0A0);
    set_exec(1, 4'd1, 32'h404, 32'hB0B0B0B0);
    tick();
    commit_cnt = 5'd2;
    tick();
    squash = 1'b1; commit_cnt = 5'd1; disp_valid = 2'b11; disp_size = {SZ_W, SZ_W};
    set_exec(0, 4'd3, 32'h40C, 32'hC0C0C0C0);
    tick();
    n_vec++; if (count !== 5'd3 || tail !== 4'd3 || head !== 4'd0) begin n_err++; $display("FAIL t5_squash: got count=%0d tail=%0d head=%0d expected 3/3/0", count, tail, head); end
    n_vec++; if (dc_req_valid !== 2'b11) begin n_err++; $display("FAIL t5_keep: got dcv=%b expected 11", dc_req_valid); end
    set_load(0, 4'd3, 32'h404, SZ_W);
    #1;
    n_vec++; if (ld_wait[0] !== 1'b1) begin n_err++; $display("FAIL t5_survivor_unready: got w=%b expected 1", ld_wait[0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    disp(2'b11, SZ_W, SZ_W);
    set_exec(1, 4'd1, 32'h504, 32'h55555555);
    commit_cnt = 5'd2;
    tick();
    n_vec++; if (dc_req_valid !== 2'b00) begin n_err++; $display("FAIL t6_gap: got dcv=%b expected 00", dc_req_valid); end
    set_exec(0, 4'd0, 32'h500, 32'h44444444);
    tick();
    dc_accept = 2'b10;
    #1;
    n_vec++; if (dc_req_valid !== 2'b11 || drained_cnt !== 5'd0) begin n_err++; $display("FAIL t6_nonprefix: got dcv=%b drained=%0d expected 11/0", dc_req_valid, drained_cnt); end
    tick();
    n_vec++; if (head !== 4'd0 || count !== 5'd2 || dc_req_valid !== 2'b11) begin n_err++; $display("FAIL t6_represent: got head=%0d count=%0d dcv=%b expected 0/2/11", head, count, dc_req_valid); end
    reset = 1'b1;
    dc_accept = 2'b11;
    tick();
    n_vec++; if (head !== 4'd0 || tail !== 4'd0 || count !== 5'd0 || dc_req_valid !== 2'b00 || drained_cnt !== 5'd0) begin
      n_err++; $display("FAIL t6_reset: got head=%0d tail=%0d count=%0d dcv=%b drained=%0d expected all 0", head, tail, count, dc_req_valid, drained_cnt); end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    test_reset();
    test_basic_drain();
    test_full_wrap();
    test_partial_fwd();
    test_wait();
    test_squash();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
